// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// instruction width and the NOP word presented while nothing is held.
package instruction_fetch_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/acknowledge bus. The fetch stage is the master,
// the instruction memory is the slave.
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic [31:0]        imem_addr;
    logic               imem_req;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/instruction_fetch_next_pc_calc.sv
// Combinational next-PC selection from the decoder's redirect controls.
// Priority: jump-register, then jump/jump-and-link, then taken branch,
// otherwise sequential. A jump-register target with low bits set is
// word-aligned here and flagged so the caller can record the error.
module instruction_fetch_next_pc_calc
    import instruction_fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        jl_i,
    input  logic        jal_i,
    input  logic        jr_i,
    input  logic        branch_i,
    input  logic        branch_taken_i,
    input  logic [25:0] target_address_i,
    input  logic [15:0] imm16_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] next_pc_o,
    output logic        misaligned_o
);

    logic [31:0] seq_pc;
    logic [31:0] branch_off;

    // Pick the redirect target by priority; all additions wrap modulo 2^32.
    always_comb begin
        seq_pc       = pc_i + 32'd4;
        branch_off   = {{14{imm16_i[15]}}, imm16_i, 2'b00};
        next_pc_o    = seq_pc;
        misaligned_o = 1'b0;
        if (jr_i) begin
            next_pc_o    = {jr_target_i[31:2], 2'b00};
            misaligned_o = |jr_target_i[1:0];
        end else if (jl_i | jal_i) begin
            next_pc_o = {seq_pc[31:28], target_address_i, 2'b00};
        end else if (branch_i & branch_taken_i) begin
            next_pc_o = seq_pc + branch_off;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, fetches one word per instruction over the
// imem req/ack bus, presents it to the decoder and advances the PC once
// the consumer releases the instruction.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | one cycle after reset, nothing requested yet
//   ST_FETCH | imem_req high at pc, waiting for imem_ack (wait counter runs)
//   ST_HOLD  | instruction valid and stable, waiting for instr_ready
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic                      clk,
    input  logic                      reset_n,
    instruction_fetch_if.master       imem,
    output logic [INSTR_W-1:0]        instruction,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [31:0]               pc,
    output logic [31:0]               pc_plus4,
    input  logic                      jl,
    input  logic                      jal,
    input  logic                      jr,
    input  logic                      branch,
    input  logic                      branch_taken,
    input  logic [25:0]               target_address,
    input  logic [15:0]               imm16,
    input  logic [31:0]               jr_target,
    output logic                      align_err,
    output logic                      fetch_timeout
);

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    fetch_state_e       state_q;
    logic [31:0]        pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;
    logic               req_q;
    logic [7:0]         wait_q;
    logic [7:0]         wait_d;
    logic               align_q;
    logic               timeout_q;

    logic [31:0]        next_pc;
    logic               misaligned;

    instruction_fetch_next_pc_calc u_next_pc (
        .pc_i             (pc_q),
        .jl_i             (jl),
        .jal_i            (jal),
        .jr_i             (jr),
        .branch_i         (branch),
        .branch_taken_i   (branch_taken),
        .target_address_i (target_address),
        .imm16_i          (imm16),
        .jr_target_i      (jr_target),
        .next_pc_o        (next_pc),
        .misaligned_o     (misaligned)
    );

    // Saturating ack-wait count for the current fetch.
    always_comb begin
        wait_d = (wait_q >= WAIT_MAX) ? WAIT_MAX : wait_q + 8'd1;
    end

    // Fetch sequencing with registered request, held instruction and sticky flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_WORD;
            valid_q   <= 1'b0;
            req_q     <= 1'b0;
            wait_q    <= 8'd0;
            align_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_FETCH;
                    req_q   <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem.imem_ack) begin
                        instr_q <= imem.imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        wait_q  <= 8'd0;
                        state_q <= ST_HOLD;
                    end else begin
                        wait_q <= wait_d;
                        if (wait_d == WAIT_MAX) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        pc_q    <= next_pc;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= ST_FETCH;
                        if (misaligned) begin
                            align_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_addr = pc_q;
    assign imem.imem_req  = req_q;
    assign instruction    = instr_q;
    assign instr_valid    = valid_q;
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign align_err      = align_q;
    assign fetch_timeout  = timeout_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by randomized
// traffic, with a transaction-level reference model compared every cycle.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          MW     = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] instruction, pc, pc_plus4, jr_target;
    logic        instr_valid, instr_ready;
    logic        jl, jal, jr, branch, branch_taken;
    logic [25:0] target_address;
    logic [15:0] imm16;
    logic        align_err, fetch_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch_if imem_bus ();

    instruction_fetch #(.RESET_PC(RST_PC), .MAX_WAIT(MW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem           (imem_bus),
        .instruction    (instruction),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .jl             (jl),
        .jal            (jal),
        .jr             (jr),
        .branch         (branch),
        .branch_taken   (branch_taken),
        .target_address (target_address),
        .imm16          (imm16),
        .jr_target      (jr_target),
        .align_err      (align_err),
        .fetch_timeout  (fetch_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'hC0DE_1357;
    endfunction

    // Reference next-PC from the redirect rules.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic jr_, input logic jl_,
                                             input logic jal_, input logic br_, input logic bt_,
                                             input logic [25:0] ta, input logic [15:0] imm,
                                             input logic [31:0] jrt);
        logic [31:0] seq;
        logic [31:0] sx;
        seq = cur + 32'd4;
        sx  = {{16{imm[15]}}, imm};
        if (jr_) return jrt & 32'hFFFF_FFFC;
        if (jl_ || jal_) return (seq & 32'hF000_0000) | ({6'b0, ta} * 32'd4);
        if (br_ && bt_) return seq + sx * 32'd4;
        return seq;
    endfunction

    // Reference model: phase flags rather than a state register.
    logic        m_live = 1'b0;
    logic        m_idle, m_req, m_valid, m_to, m_al;
    logic [31:0] m_pc, m_instr;
    int          m_wait;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_live  <= 1'b1;
            m_idle  <= 1'b1;
            m_req   <= 1'b0;
            m_valid <= 1'b0;
            m_pc    <= RST_PC;
            m_instr <= NOP_WORD;
            m_wait  <= 0;
            m_to    <= 1'b0;
            m_al    <= 1'b0;
        end else if (m_live) begin
            if (m_idle) begin
                m_idle <= 1'b0;
                m_req  <= 1'b1;
            end else if (m_req) begin
                if (imem_bus.imem_ack) begin
                    m_instr <= imem_bus.imem_rdata;
                    m_valid <= 1'b1;
                    m_req   <= 1'b0;
                    m_wait  <= 0;
                end else begin
                    m_wait <= (m_wait + 1 > MW) ? MW : m_wait + 1;
                    if (m_wait + 1 >= MW) m_to <= 1'b1;
                end
            end else if (m_valid && instr_ready) begin
                m_pc    <= ref_next(m_pc, jr, jl, jal, branch, branch_taken, target_address, imm16, jr_target);
                m_valid <= 1'b0;
                m_req   <= 1'b1;
                if (jr && jr_target[1:0] != 2'b00) m_al <= 1'b1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("imem_req",      32'(imem_bus.imem_req), 32'(m_req));
            chk("imem_addr",     imem_bus.imem_addr,     m_pc);
            chk("pc",            pc,                     m_pc);
            chk("pc_plus4",      pc_plus4,               m_pc + 32'd4);
            chk("instr_valid",   32'(instr_valid),       32'(m_valid));
            chk("instruction",   instruction,            m_instr);
            chk("align_err",     32'(align_err),         32'(m_al));
            chk("fetch_timeout", 32'(fetch_timeout),     32'(m_to));
        end
    end

    task automatic fetch(input int waits);
        for (int i = 0; i < waits; i++) begin
            imem_bus.imem_ack = 1'b0;
            @(negedge clk);
        end
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
        @(negedge clk);
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = $urandom;
    endtask

    task automatic retire(input logic jr_, input logic jl_, input logic jal_, input logic br_,
                          input logic bt_, input logic [25:0] ta, input logic [15:0] imm,
                          input logic [31:0] jrt);
        jr = jr_; jl = jl_; jal = jal_; branch = br_; branch_taken = bt_;
        target_address = ta; imm16 = imm; jr_target = jrt;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        jr = 1'b0; jl = 1'b0; jal = 1'b0; branch = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        reset_n = 1'b0;
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0;
        instr_ready = 1'b0;
        jl = 1'b0; jal = 1'b0; jr = 1'b0; branch = 1'b0; branch_taken = 1'b0;
        target_address = 26'h0; imm16 = 16'h0; jr_target = 32'h0;

        // Pin the reference next-PC function with hand-computed values.
        chk("model_jl",     ref_next(32'h0040_0010, 0, 1, 0, 0, 0, 26'h010_0008, 16'h0, 32'h0), 32'h0040_0020);
        chk("model_br",     ref_next(32'h0000_0100, 0, 0, 0, 1, 1, 26'h0, 16'hFFFE, 32'h0), 32'h0000_00FC);
        chk("model_jr",     ref_next(32'h0000_0000, 1, 1, 0, 0, 0, 26'h3FF_FFFF, 16'h0, 32'h0000_2003), 32'h0000_2000);
        chk("model_wrap",   ref_next(32'hFFFF_FFFC, 0, 0, 0, 1, 0, 26'h0, 16'h7FFF, 32'h0), 32'h0000_0000);

        repeat (2) @(negedge clk);
        chk("rst_req",   32'(imem_bus.imem_req), 32'h0);
        chk("rst_pc",    pc,                     32'h0);
        chk("rst_valid", 32'(instr_valid),       32'h0);
        chk("rst_instr", instruction,            32'h0);

        reset_n = 1'b1;
        @(negedge clk);
        chk("first_req",  32'(imem_bus.imem_req), 32'h1);
        chk("first_addr", imem_bus.imem_addr,     32'h0);
        fetch(0);
        chk("first_valid", 32'(instr_valid), 32'h1);
        chk("first_instr", instruction,      mem_word(32'h0));
        retire(0, 0, 0, 0, 0, 26'h0, 16'h0, 32'h0);
        chk("seq_addr", imem_bus.imem_addr, 32'h0000_0004);

        fetch(0);
        retire(1, 0, 0, 0, 0, 26'h0, 16'h0, 32'h0040_0010);
        fetch(0);
        retire(0, 1, 0, 0, 0, 26'h010_0008, 16'h0, 32'h0);
        chk("jl_addr", imem_bus.imem_addr, 32'h0040_0020);

        fetch(0);
        retire(1, 0, 0, 0, 0, 26'h0, 16'h0, 32'h0000_0100);
        fetch(0);
        retire(0, 0, 0, 1, 1, 26'h0, 16'hFFFE, 32'h0);
        chk("br_taken_addr", imem_bus.imem_addr, 32'h0000_00FC);
        fetch(0);
        retire(1, 0, 0, 0, 0, 26'h0, 16'h0, 32'h0000_0100);
        fetch(0);
        retire(0, 0, 0, 1, 0, 26'h0, 16'hFFFE, 32'h0);
        chk("br_not_taken_addr", imem_bus.imem_addr, 32'h0000_0104);

        fetch(0);
        retire(1, 1, 0, 0, 0, 26'h3FF_FFFF, 16'h0, 32'h0000_2003);
        chk("jr_prio_addr", imem_bus.imem_addr, 32'h0000_2000);
        chk("align_set",    32'(align_err),     32'h1);

        // Ack withheld for five cycles, captured on the sixth.
        a = imem_bus.imem_addr;
        for (int i = 1; i <= 5; i++) begin
            imem_bus.imem_ack = 1'b0;
            @(negedge clk);
            chk("timeout_wait", 32'(fetch_timeout), (i >= 3) ? 32'h1 : 32'h0);
            chk("req_held",     32'(imem_bus.imem_req), 32'h1);
        end
        fetch(0);
        chk("late_valid", 32'(instr_valid), 32'h1);
        chk("late_instr", instruction,      mem_word(a));
        chk("align_sticky", 32'(align_err), 32'h1);

        // Reset during a wait, then a stray ack while idle.
        retire(0, 0, 0, 0, 0, 26'h0, 16'h0, 32'h0);
        imem_bus.imem_ack = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst2_valid",   32'(instr_valid),   32'h0);
        chk("rst2_pc",      pc,                 RST_PC);
        chk("rst2_align",   32'(align_err),     32'h0);
        chk("rst2_timeout", 32'(fetch_timeout), 32'h0);
        reset_n = 1'b1;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_bus.imem_ack = 1'b0;
        chk("rst2_req",    32'(imem_bus.imem_req), 32'h1);
        chk("rst2_valid2", 32'(instr_valid),       32'h0);
        chk("rst2_addr",   imem_bus.imem_addr,     RST_PC);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            reset_n             = ($urandom_range(0, 299) != 0);
            imem_bus.imem_ack   = ($urandom_range(0, 2) == 0);
            imem_bus.imem_rdata = imem_bus.imem_ack ? mem_word(imem_bus.imem_addr) : $urandom;
            instr_ready         = 1'($urandom_range(0, 1));
            jr                  = ($urandom_range(0, 5) == 0);
            jl                  = ($urandom_range(0, 5) == 0);
            jal                 = ($urandom_range(0, 5) == 0);
            branch              = ($urandom_range(0, 2) == 0);
            branch_taken        = 1'($urandom_range(0, 1));
            target_address      = 26'($urandom);
            imm16               = 16'($urandom);
            jr_target           = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly upstream of the instruction decoder. It holds the PC and fetches one 32-bit word per instruction from instruction memory over a req/ack handshake. It presents the held word to the decoder and computes the next PC from the decoder's control outputs once the consumer releases the instruction. Also supplies PC+4 for jal linking.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
MAX_WAIT, 15, ack-wait cycles in FETCH before fetch_timeout sets; range 1..255.

Ports:
clk  in  1  single clock, all state on rising edge
reset_n  in  1  synchronous, active-low reset
imem_addr  out  32  fetch address (= pc)
imem_req  out  1  fetch request
imem_ack  in  1  read data valid this cycle
imem_rdata  in  32  instruction word
instruction  out  32  held instruction to decoder
instr_valid  out  1  instruction holds a fetched word
instr_ready  in  1  consumer has finished with instruction
pc  out  32  address of held instruction
pc_plus4  out  32  pc + 4 (link value)
jl  in  1  decoded plain jump
jal  in  1  decoded jump-and-link
jr  in  1  decoded jump-register
branch  in  1  decoded branch
branch_taken  in  1  branch condition true (ALU zero, qualified by caller)
target_address  in  26  decoded J-type target
imm16  in  16  decoded immediate
jr_target  in  32  rs register value
align_err  out  1  sticky: jr_target[1:0] nonzero was used
fetch_timeout  out  1  sticky: MAX_WAIT reached in one fetch

Behaviour:
- Reset (reset_n low at edge): state=IDLE, pc=RESET_PC, imem_req=0, instruction=32'h0 (NOP), instr_valid=0, wait counter=0, align_err=0, fetch_timeout=0. Overrides all else. A request in flight is abandoned, and any late ack is ignored because imem_req is low.
- FSM: IDLE -> FETCH unconditionally (one cycle after reset release).
- FETCH: imem_req=1, imem_addr=pc. On imem_ack, the edge captures instruction<=imem_rdata, instr_valid<=1, state<=HOLD, wait counter<=0.
- FETCH without ack: wait counter increments and saturates at MAX_WAIT. Reaching MAX_WAIT sets fetch_timeout. The request stays asserted; no abort.
- HOLD: imem_req=0; instruction, pc and instr_valid are stable. When instr_ready=1, the edge sets pc<=next_pc, instr_valid<=0, state<=FETCH.
- instr_ready outside HOLD is ignored. Redirect inputs are sampled only on the HOLD & instr_ready edge.
- next_pc priority, computed combinationally from current pc:
  1. jr: {jr_target[31:2],2'b00}; if jr_target[1:0]!=0, set align_err.
  2. jl|jal: {pc_plus4[31:28], target_address, 2'b00}.
  3. branch & branch_taken: pc_plus4 + ({{14{imm16[15]}},imm16,2'b00}).
  4. otherwise: pc_plus4.
- All arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Throughput: with a zero-wait ack, an instruction takes 2 cycles (FETCH, HOLD with instr_ready=1). Each wait state adds 1 cycle.
- pc_plus4 is combinational from pc, valid in every state.

Decomposition:
- Shared package: FSM state encodings (IDLE, FETCH, HOLD), NOP word 32'h0, instruction width 32.
- Sub-module next_pc_calc: purely combinational. Inputs are pc, the redirect controls, target_address, imm16 and jr_target. Outputs are next_pc and misaligned. The FSM, registers and counter stay in instruction_fetch.

Test Plan:
- Reset with RESET_PC=0, memory acks next cycle with no wait -> imem_req rises the cycle after release with addr 0. instruction=mem[0] and instr_valid=1 the following cycle. With no redirect and instr_ready=1, the next fetch addr is 4.
- pc=0x0040_0010, jl=1, target_address=26'h010_0008 -> next imem_addr=0x0040_0020.
- pc=0x0000_0100, branch=1, branch_taken=1, imm16=16'hFFFE -> next addr 0x0000_00FC. Same stimulus with branch_taken=0 -> 0x0000_0104.
- jr=1 together with jl=1, jr_target=0x0000_2003 -> next addr 0x0000_2000, align_err=1 and stays set until reset.
- MAX_WAIT=3, ack withheld 5 cycles -> fetch_timeout sets at the 3rd wait cycle and imem_req stays high. Ack on the 6th cycle is captured normally.
- reset_n low for 1 cycle during a FETCH wait, then ack arrives the next cycle -> ack ignored, instr_valid=0, pc=RESET_PC. A fresh request is issued one cycle later.
